// File: rtl/mmu_port_arbiter_pkg.sv
// Shared types for the MMU port arbiter: MMU command/register/exception codes,
// memory access type, arbiter FSM states and requester ids.
package mmu_port_arbiter_pkg;

  localparam int MMU_CMD_W = 3;
  localparam int MMU_REG_W = 3;
  localparam int MMU_EXC_W = 3;

  typedef enum logic {
    MEM_ACCESS_R = 1'b0,
    MEM_ACCESS_W = 1'b1
  } mem_access_e;

  typedef enum logic [MMU_CMD_W-1:0] {
    MMU_CMD_NONE      = 3'd0,
    MMU_CMD_READ_REG  = 3'd1,
    MMU_CMD_WRITE_REG = 3'd2,
    MMU_CMD_READ_TLB  = 3'd3,
    MMU_CMD_WRITE_TLB = 3'd4,
    MMU_CMD_PROBE_TLB = 3'd5
  } mmu_cmd_e;

  typedef enum logic [MMU_REG_W-1:0] {
    MMU_REG_INDEX    = 3'd0,
    MMU_REG_RANDOM   = 3'd1,
    MMU_REG_ENTRYLO0 = 3'd2,
    MMU_REG_ENTRYLO1 = 3'd3,
    MMU_REG_CONTEXT  = 3'd4,
    MMU_REG_PAGEMASK = 3'd5,
    MMU_REG_WIRED    = 3'd6,
    MMU_REG_ENTRYHI  = 3'd7
  } mmu_reg_e;

  typedef enum logic [MMU_EXC_W-1:0] {
    MMU_EXC_NONE = 3'd0,
    MMU_EXC_TLBL = 3'd1,
    MMU_EXC_TLBS = 3'd2,
    MMU_EXC_MOD  = 3'd3,
    MMU_EXC_ADEL = 3'd4,
    MMU_EXC_ADES = 3'd5
  } mmu_exception_e;

  typedef enum logic [1:0] {
    MMU_ARB_IDLE  = 2'd0,
    MMU_ARB_ISSUE = 2'd1,
    MMU_ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    MMU_ARB_IF  = 2'd0,
    MMU_ARB_DM  = 2'd1,
    MMU_ARB_CMD = 2'd2
  } arb_id_e;

  // Winner id plus the inputs captured at accept; only the winner's fields change.
  typedef struct packed {
    logic [1:0]           id;
    logic [31:0]          vaddr;
    logic                 acc;
    logic [MMU_CMD_W-1:0] op;
    logic [MMU_REG_W-1:0] rg;
    logic [31:0]          wdata;
  } arb_latch_t;

endpackage

// File: rtl/mmu_rr_arbiter.sv
// Three-way grant: CMD has absolute priority, IF/DM share round-robin through
// a one-bit pointer remembering which of the two was granted last.
module mmu_rr_arbiter
  import mmu_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       accept,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       cmd_req,
  output logic       grant_valid,
  output logic [1:0] grant_id
);

  logic last_dm;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = if_req | dm_req | cmd_req;
    grant_id    = MMU_ARB_DM;
    if (cmd_req) begin
      grant_id = MMU_ARB_CMD;
    end else if (if_req && (!dm_req || last_dm)) begin
      grant_id = MMU_ARB_IF;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      last_dm <= 1'b1;
    end else if (accept && grant_valid && !cmd_req) begin
      last_dm <= (grant_id == MMU_ARB_DM);
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Serialises IF, DM and CP0 command traffic onto the single MMU port:
// IDLE accepts a winner, ISSUE drives the MMU, RESP returns the result.
module mmu_port_arbiter
  import mmu_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 res,
  input  logic                 if_req,
  input  logic [31:0]          if_vaddr,
  output logic                 if_done,
  output logic [31:0]          if_paddr,
  output logic [MMU_EXC_W-1:0] if_exc,
  input  logic                 dm_req,
  input  logic [31:0]          dm_vaddr,
  input  logic                 dm_acc,
  output logic                 dm_done,
  output logic [31:0]          dm_paddr,
  output logic [MMU_EXC_W-1:0] dm_exc,
  input  logic                 cmd_req,
  input  logic [MMU_CMD_W-1:0] cmd_op,
  input  logic [MMU_REG_W-1:0] cmd_reg,
  input  logic [31:0]          cmd_wdata,
  output logic                 cmd_done,
  output logic [31:0]          cmd_rdata,
  output logic                 mmu_addrValid,
  output logic [31:0]          mmu_vAddr,
  output logic                 mmu_accessType,
  output logic [MMU_CMD_W-1:0] mmu_cmd,
  output logic [MMU_REG_W-1:0] mmu_reg,
  output logic [31:0]          mmu_dataIn,
  input  logic [31:0]          mmu_pAddr,
  input  logic [MMU_EXC_W-1:0] mmu_exception,
  input  logic [31:0]          mmu_dataOut
);

  arb_state_e state_q, state_d;
  arb_latch_t latch_q;
  logic       accept;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       issue;
  logic       resp;
  logic       is_cmd;
  logic [31:0] tr_paddr;

  assign accept = (state_q == MMU_ARB_IDLE);

  mmu_rr_arbiter u_rr (
    .clk         (clk),
    .res         (res),
    .accept      (accept),
    .if_req      (if_req),
    .dm_req      (dm_req),
    .cmd_req     (cmd_req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MMU_ARB_IDLE:  if (grant_valid) state_d = MMU_ARB_ISSUE;
      MMU_ARB_ISSUE: state_d = MMU_ARB_RESP;
      MMU_ARB_RESP:  state_d = MMU_ARB_IDLE;
      default:       state_d = MMU_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= MMU_ARB_IDLE;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && grant_valid) begin
        latch_q.id <= grant_id;
        if (grant_id == MMU_ARB_CMD) begin
          latch_q.op    <= cmd_op;
          latch_q.rg    <= cmd_reg;
          latch_q.wdata <= cmd_wdata;
        end else if (grant_id == MMU_ARB_IF) begin
          latch_q.vaddr <= if_vaddr;
          latch_q.acc   <= MEM_ACCESS_R;
        end else begin
          latch_q.vaddr <= dm_vaddr;
          latch_q.acc   <= dm_acc;
        end
      end
    end
  end

  // Strobes exist only in ISSUE; the data buses simply hold the last latched values.
  assign issue          = (state_q == MMU_ARB_ISSUE);
  assign is_cmd         = (latch_q.id == MMU_ARB_CMD);
  assign mmu_addrValid  = issue && !is_cmd;
  assign mmu_cmd        = (issue && is_cmd) ? latch_q.op : MMU_CMD_NONE;
  assign mmu_vAddr      = latch_q.vaddr;
  assign mmu_accessType = latch_q.acc;
  assign mmu_reg        = latch_q.rg;
  assign mmu_dataIn     = latch_q.wdata;

  // Gating with res keeps a response from escaping while a reset abandons it.
  assign resp     = (state_q == MMU_ARB_RESP) && !res;
  assign tr_paddr = (mmu_exception == MMU_EXC_NONE) ? mmu_pAddr : '0;

  always_comb begin
    if_done   = 1'b0;
    if_paddr  = '0;
    if_exc    = MMU_EXC_NONE;
    dm_done   = 1'b0;
    dm_paddr  = '0;
    dm_exc    = MMU_EXC_NONE;
    cmd_done  = 1'b0;
    cmd_rdata = '0;
    if (resp) begin
      case (latch_q.id)
        MMU_ARB_IF: begin
          if_done  = 1'b1;
          if_paddr = tr_paddr;
          if_exc   = mmu_exception;
        end
        MMU_ARB_DM: begin
          dm_done  = 1'b1;
          dm_paddr = tr_paddr;
          dm_exc   = mmu_exception;
        end
        MMU_ARB_CMD: begin
          cmd_done  = 1'b1;
          cmd_rdata = mmu_dataOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Self-checking bench: a small behavioural MMU answers the port, and a
// transaction-level model predicts every grant, pulse and routed value.
module tb_mmu_port_arbiter;
  import mmu_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res;
  logic        if_req, dm_req, cmd_req;
  logic [31:0] if_vaddr, dm_vaddr, cmd_wdata;
  logic        dm_acc;
  logic [2:0]  cmd_op, cmd_reg;
  logic        if_done, dm_done, cmd_done;
  logic [31:0] if_paddr, dm_paddr, cmd_rdata;
  logic [2:0]  if_exc, dm_exc;
  logic        mmu_addrValid, mmu_accessType;
  logic [31:0] mmu_vAddr, mmu_dataIn;
  logic [2:0]  mmu_cmd, mmu_reg;
  logic [31:0] mmu_pAddr = '0;
  logic [2:0]  mmu_exception = '0;
  logic [31:0] mmu_dataOut = '0;

  mmu_port_arbiter dut (
    .clk(clk), .res(res),
    .if_req(if_req), .if_vaddr(if_vaddr), .if_done(if_done), .if_paddr(if_paddr), .if_exc(if_exc),
    .dm_req(dm_req), .dm_vaddr(dm_vaddr), .dm_acc(dm_acc), .dm_done(dm_done), .dm_paddr(dm_paddr),
    .dm_exc(dm_exc),
    .cmd_req(cmd_req), .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
    .mmu_addrValid(mmu_addrValid), .mmu_vAddr(mmu_vAddr), .mmu_accessType(mmu_accessType),
    .mmu_cmd(mmu_cmd), .mmu_reg(mmu_reg), .mmu_dataIn(mmu_dataIn),
    .mmu_pAddr(mmu_pAddr), .mmu_exception(mmu_exception), .mmu_dataOut(mmu_dataOut)
  );

  // ---------------- behavioural MMU (registers its answer on the ISSUE edge)
  logic [31:0] mock_regs [8] = '{default: '0};
  logic [31:0] tlb_hi    [4] = '{default: '0};
  logic [31:0] tlb_lo0   [4] = '{default: '0};

  // kseg0/kseg1 unmapped; otherwise even-page TLB lookup. A miss returns the
  // raw vaddr as paddr so the arbiter's zero-forcing is visible.
  function automatic logic [34:0] translate(input logic [31:0] va, input logic wr);
    logic [2:0] miss;
    miss = wr ? MMU_EXC_TLBS : MMU_EXC_TLBL;
    if (va[31:30] == 2'b10) return {MMU_EXC_NONE, 3'b000, va[28:0]};
    for (int i = 0; i < 4; i++)
      if (tlb_hi[i][31:13] == va[31:13] && tlb_hi[i][7:0] == mock_regs[MMU_REG_ENTRYHI][7:0]
          && !va[12] && tlb_lo0[i][1])
        return {MMU_EXC_NONE, tlb_lo0[i][25:6], va[11:0]};
    return {miss, va};
  endfunction

  always @(posedge clk) begin
    if (mmu_addrValid) {mmu_exception, mmu_pAddr} <= translate(mmu_vAddr, mmu_accessType);
    case (mmu_cmd)
      MMU_CMD_NONE: ;
      MMU_CMD_WRITE_REG: begin
        mock_regs[mmu_reg] <= mmu_dataIn;
        mmu_dataOut        <= mmu_dataIn;
      end
      MMU_CMD_READ_REG: mmu_dataOut <= mock_regs[mmu_reg];
      MMU_CMD_WRITE_TLB: begin
        tlb_hi[mock_regs[MMU_REG_INDEX][1:0]]  <= mock_regs[MMU_REG_ENTRYHI];
        tlb_lo0[mock_regs[MMU_REG_INDEX][1:0]] <= mock_regs[MMU_REG_ENTRYLO0];
        mmu_dataOut <= '0;
      end
      default: mmu_dataOut <= '0;
    endcase
  end

  // ---------------- checking
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model
  int          m_phase  = 0;   // cycles into the current transaction: 0 idle, 1 issue, 2 resp
  int          m_win    = 0;   // 0 IF, 1 DM, 2 CMD
  bit          m_last_dm = 1'b1;
  logic [31:0] m_vaddr, m_wdata, m_exp_paddr, m_exp_rdata;
  logic        m_acc;
  logic [2:0]  m_op, m_reg, m_exp_exc;

  task automatic model_edge();
    logic [34:0] tr;
    if (res) begin
      m_phase   = 0;
      m_last_dm = 1'b1;
    end else if (m_phase == 0) begin
      if (cmd_req || if_req || dm_req) begin
        if (cmd_req) m_win = 2;
        else if (if_req && dm_req) m_win = m_last_dm ? 0 : 1;
        else m_win = if_req ? 0 : 1;
        if (m_win != 2) m_last_dm = (m_win == 1);
        if (m_win == 2) begin
          m_op = cmd_op; m_reg = cmd_reg; m_wdata = cmd_wdata;
          m_exp_rdata = (cmd_op == MMU_CMD_WRITE_REG) ? cmd_wdata :
                        (cmd_op == MMU_CMD_READ_REG)  ? mock_regs[cmd_reg] : 32'h0;
        end else begin
          m_vaddr = (m_win == 0) ? if_vaddr : dm_vaddr;
          m_acc   = (m_win == 0) ? 1'b0 : dm_acc;
          tr = translate(m_vaddr, m_acc);
          m_exp_exc   = tr[34:32];
          m_exp_paddr = (tr[34:32] == MMU_EXC_NONE) ? tr[31:0] : 32'h0;
        end
        m_phase = 1;
      end
    end else begin
      m_phase = (m_phase == 1) ? 2 : 0;
    end
  endtask

  task automatic model_check();
    bit rsp, iss;
    rsp = (m_phase == 2) && !res;
    iss = (m_phase == 1);
    check("if_done",   if_done,   rsp && m_win == 0);
    check("dm_done",   dm_done,   rsp && m_win == 1);
    check("cmd_done",  cmd_done,  rsp && m_win == 2);
    check("if_paddr",  if_paddr,  (rsp && m_win == 0) ? m_exp_paddr : 32'h0);
    check("if_exc",    if_exc,    (rsp && m_win == 0) ? m_exp_exc : MMU_EXC_NONE);
    check("dm_paddr",  dm_paddr,  (rsp && m_win == 1) ? m_exp_paddr : 32'h0);
    check("dm_exc",    dm_exc,    (rsp && m_win == 1) ? m_exp_exc : MMU_EXC_NONE);
    check("cmd_rdata", cmd_rdata, (rsp && m_win == 2) ? m_exp_rdata : 32'h0);
    check("mmu_av",    mmu_addrValid, iss && m_win != 2);
    check("mmu_cmd",   mmu_cmd,   (iss && m_win == 2) ? m_op : MMU_CMD_NONE);
    if (iss && m_win != 2) begin
      check("mmu_vaddr", mmu_vAddr, m_vaddr);
      check("mmu_acc",   mmu_accessType, m_acc);
    end
    if (iss && m_win == 2) begin
      check("mmu_reg",   mmu_reg, m_reg);
      check("mmu_din",   mmu_dataIn, m_wdata);
    end
  endtask

  // ---------------- cycle stepping and observation
  int          cyc = 0;
  int          cmd_active_cnt = 0;
  bit          obs_done [3];
  int          done_log[$];
  int          cyc_log[$];
  logic [31:0] cap_if_paddr, cap_dm_paddr, cap_rdata;
  logic [2:0]  cap_if_exc, cap_dm_exc;

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    model_check();
    obs_done[0] = if_done;
    obs_done[1] = dm_done;
    obs_done[2] = cmd_done;
    if (mmu_cmd != MMU_CMD_NONE) cmd_active_cnt++;
    if (if_done)  begin done_log.push_back(0); cyc_log.push_back(cyc); cap_if_paddr = if_paddr; cap_if_exc = if_exc; end
    if (dm_done)  begin done_log.push_back(1); cyc_log.push_back(cyc); cap_dm_paddr = dm_paddr; cap_dm_exc = dm_exc; end
    if (cmd_done) begin done_log.push_back(2); cyc_log.push_back(cyc); cap_rdata = cmd_rdata; end
  endtask

  task automatic wait_done(input int who, output int lat);
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      lat++;
      if (obs_done[who]) break;
    end
    check("done_timeout", obs_done[who], 1'b1);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rg, input logic [31:0] wd);
    int lat;
    cmd_op = op; cmd_reg = rg; cmd_wdata = wd; cmd_req = 1'b1;
    wait_done(2, lat);
    cmd_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_va();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_4000 | 32'($urandom_range(0, 32'h1FFF));
      1:       return 32'h0000_3000 | 32'($urandom_range(0, 32'hFFF));
      2:       return 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    res = 1'b1;
    if_req = 1'b1; if_vaddr = 32'h0000_400C;
    dm_req = 1'b1; dm_vaddr = 32'h8123_4567; dm_acc = MEM_ACCESS_R;
    cmd_req = 1'b1; cmd_op = MMU_CMD_WRITE_REG; cmd_reg = MMU_REG_INDEX; cmd_wdata = 32'h0;

    // Reset with everything requesting: silence, then CMD, IF, DM.
    tick();
    tick();
    check("rst_no_done", {29'h0, obs_done[0], obs_done[1], obs_done[2]}, 32'h0);
    res = 1'b0;
    done_log.delete(); cyc_log.delete();
    for (int c = 0; c < 20 && done_log.size() < 3; c++) begin
      tick();
      if (obs_done[0]) if_req  = 1'b0;
      if (obs_done[1]) dm_req  = 1'b0;
      if (obs_done[2]) cmd_req = 1'b0;
    end
    check("rst_order_n", done_log.size(), 3);
    if (done_log.size() == 3) begin
      check("rst_first_cmd", done_log[0], 2);
      check("rst_then_if",   done_log[1], 0);
      check("rst_then_dm",   done_log[2], 1);
    end

    // TLB entry: VPN2=2, ASID=1, PFN=20 (valid, dirty) into index 0.
    do_cmd(MMU_CMD_WRITE_REG, MMU_REG_INDEX,    32'h0);
    do_cmd(MMU_CMD_WRITE_REG, MMU_REG_ENTRYHI,  32'h0000_4001);
    do_cmd(MMU_CMD_WRITE_REG, MMU_REG_PAGEMASK, 32'h0);
    do_cmd(MMU_CMD_WRITE_REG, MMU_REG_ENTRYLO0, (32'd20 << 6) | 32'h6);
    do_cmd(MMU_CMD_WRITE_TLB, MMU_REG_INDEX,    32'h0);

    tick();
    if_vaddr = 32'h0000_400C; if_req = 1'b1;
    wait_done(0, lat);
    if_req = 1'b0;
    check("if_latency", lat, 2);
    check("if_mapped_pa", cap_if_paddr, 32'h0001_400C);
    check("if_mapped_exc", cap_if_exc, MMU_EXC_NONE);

    // IF and DM held together: alternate, starting with DM since IF went last.
    done_log.delete(); cyc_log.delete();
    if_req = 1'b1; dm_req = 1'b1; dm_vaddr = 32'h8123_4567; dm_acc = MEM_ACCESS_R;
    for (int c = 0; c < 25 && done_log.size() < 4; c++) tick();
    if_req = 1'b0; dm_req = 1'b0;
    check("alt_n", done_log.size(), 4);
    for (int i = 0; i < done_log.size(); i++) begin
      check("alt_order", done_log[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check("alt_spacing", cyc_log[i] - cyc_log[i-1], 3);
    end
    check("dm_kseg0_pa", cap_dm_paddr, 32'h0123_4567);

    // TLB misses: store -> TLBS, fetch -> TLBL, paddr forced to zero.
    tick();
    dm_vaddr = 32'h0000_3000; dm_acc = MEM_ACCESS_W; dm_req = 1'b1;
    wait_done(1, lat);
    dm_req = 1'b0;
    check("dm_miss_exc", cap_dm_exc, MMU_EXC_TLBS);
    check("dm_miss_pa",  cap_dm_paddr, 32'h0);
    tick();
    if_vaddr = 32'h0000_3000; if_req = 1'b1;
    wait_done(0, lat);
    if_req = 1'b0;
    check("if_miss_exc", cap_if_exc, MMU_EXC_TLBL);
    check("if_miss_pa",  cap_if_paddr, 32'h0);

    // CMD arriving while IF is in ISSUE waits for the next IDLE.
    tick();
    if_vaddr = 32'h0000_400C; if_req = 1'b1;
    tick();
    cmd_op = MMU_CMD_READ_REG; cmd_reg = MMU_REG_ENTRYHI; cmd_wdata = 32'h0; cmd_req = 1'b1;
    cmd_active_cnt = 0;
    tick();
    check("ovl_if_done", obs_done[0], 1'b1);
    check("ovl_cmd_wait", obs_done[2], 1'b0);
    check("ovl_if_pa", cap_if_paddr, 32'h0001_400C);
    if_req = 1'b0;
    wait_done(2, lat);
    cmd_req = 1'b0;
    check("ovl_cmd_lat", lat, 3);
    check("ovl_cmd_1cyc", cmd_active_cnt, 1);
    check("ovl_rdata", cap_rdata, 32'h0000_4001);

    // Reset while a DM request is in flight: no pulse, then a clean retry.
    tick();
    dm_vaddr = 32'h8123_4567; dm_acc = MEM_ACCESS_R; dm_req = 1'b1;
    tick();
    res = 1'b1;
    tick();
    check("abort_no_done", obs_done[1], 1'b0);
    check("abort_dm_pa", dm_paddr, 32'h0);
    check("abort_av", mmu_addrValid, 1'b0);
    res = 1'b0;
    wait_done(1, lat);
    dm_req = 1'b0;
    check("abort_retry_lat", lat, 2);
    check("abort_retry_pa", cap_dm_paddr, 32'h0123_4567);

    // Random traffic; commands stay on scratch registers so the TLB is stable.
    for (int c = 0; c < 600; c++) begin
      tick();
      if (if_req && obs_done[0]) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0; else if_vaddr = rand_va();
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_vaddr = rand_va();
      end
      if (dm_req && obs_done[1]) begin
        if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
        else begin dm_vaddr = rand_va(); dm_acc = 1'($urandom_range(0, 1)); end
      end else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1'b1; dm_vaddr = rand_va(); dm_acc = 1'($urandom_range(0, 1));
      end
      if (cmd_req && obs_done[2]) begin
        cmd_req = 1'b0;
      end else if (!cmd_req && $urandom_range(0, 7) == 0) begin
        cmd_req   = 1'b1;
        cmd_op    = $urandom_range(0, 1) ? MMU_CMD_READ_REG : MMU_CMD_WRITE_REG;
        cmd_reg   = $urandom_range(0, 1) ? MMU_REG_CONTEXT : MMU_REG_WIRED;
        cmd_wdata = $urandom;
      end
    end
    for (int c = 0; c < 40 && (if_req || dm_req || cmd_req); c++) begin
      tick();
      if (obs_done[0]) if_req  = 1'b0;
      if (obs_done[1]) dm_req  = 1'b0;
      if (obs_done[2]) cmd_req = 1'b0;
    end
    check("drain", {29'h0, if_req, dm_req, cmd_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
